// File: rtl/watch_pkg.sv
// Shared definitions for the digital watch mode controller.
//   - Mode encodings driven on watch_mode_ctrl.mode
//   - Time field widths and wrap limits
//   - Wrap-around increment helpers for hour and minute fields
package watch_pkg;

    localparam int HOUR_W = 5;
    localparam int MIN_W  = 6;

    localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;
    localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;

    typedef enum logic [2:0] {
        MODE_RUN      = 3'd0,
        MODE_SET_HR   = 3'd1,
        MODE_SET_MIN  = 3'd2,
        MODE_SET_AHR  = 3'd3,
        MODE_SET_AMIN = 3'd4
    } mode_t;

    function automatic logic [HOUR_W-1:0] inc_hour(input logic [HOUR_W-1:0] h);
        return (h == HOUR_MAX) ? '0 : h + 5'd1;
    endfunction

    function automatic logic [MIN_W-1:0] inc_min(input logic [MIN_W-1:0] m);
        return (m == MIN_MAX) ? '0 : m + 6'd1;
    endfunction

endpackage

// File: rtl/btn_conditioner.sv
// Push-button conditioner: 2-FF synchronizer, debounce filter and
// rising-edge press pulse.
//   clk, reset_n : clock, asynchronous active-low reset
//   btn          : raw asynchronous button level
//   press        : one-cycle pulse when the debounced level rises
// A button held through reset produces no press until it has been seen
// released and pressed again.
module btn_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1, sync2;
    logic [1:0]       fill;
    logic             level, level_prev, armed;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            fill       <= '0;
            level      <= 1'b0;
            level_prev <= 1'b0;
            armed      <= 1'b0;
            cnt        <= '0;
            press      <= 1'b0;
        end else begin
            sync1      <= btn;
            sync2      <= sync1;
            // fill[1] marks that sync2 now holds a real sample, not reset value
            fill       <= {fill[0], 1'b1};
            level_prev <= level;

            // Count consecutive samples that disagree with the accepted level
            if (sync2 == level)
                cnt <= '0;
            else if (cnt == CNT_LAST) begin
                level <= sync2;
                cnt   <= '0;
            end else
                cnt <= cnt + CNT_W'(1);

            // Arm only after a genuine released sample has been observed
            if (fill[1] && !sync2 && !level)
                armed <= 1'b1;

            press <= level & ~level_prev & armed;
        end
    end

endmodule

// File: rtl/watch_mode_ctrl.sv
// Watch mode controller and alarm scheduler.
//   clk, reset_n               : clock, asynchronous active-low reset
//   mode_btn, inc_btn, stop_btn: raw push-buttons
//   sec_tick                   : 1 Hz single-cycle tick
//   cur_hours/minutes/seconds  : current time from the watch counters
//   edit_hours/minutes         : time being edited, loaded on load_time
//   load_time                  : one-cycle strobe to load edit_hours:edit_minutes:00
//   alarm_hours/minutes        : stored alarm time
//   alarm_en, alarm_ring       : alarm armed, alarm ringing (level)
//   mode                       : current mode (see watch_pkg::mode_t)
module watch_mode_ctrl
    import watch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES    = 1_000_000,
    parameter int RING_SECONDS       = 60,
    parameter int INACTIVITY_SECONDS = 30
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              mode_btn,
    input  logic              inc_btn,
    input  logic              stop_btn,
    input  logic              sec_tick,
    input  logic [HOUR_W-1:0] cur_hours,
    input  logic [MIN_W-1:0]  cur_minutes,
    input  logic [MIN_W-1:0]  cur_seconds,
    output logic [HOUR_W-1:0] edit_hours,
    output logic [MIN_W-1:0]  edit_minutes,
    output logic              load_time,
    output logic [HOUR_W-1:0] alarm_hours,
    output logic [MIN_W-1:0]  alarm_minutes,
    output logic              alarm_en,
    output logic              alarm_ring,
    output logic [2:0]        mode
);

    localparam int RING_W  = $clog2(RING_SECONDS + 1);
    localparam int INACT_W = $clog2(INACTIVITY_SECONDS + 1);
    localparam logic [RING_W-1:0]  RING_LAST  = RING_W'(RING_SECONDS - 1);
    localparam logic [INACT_W-1:0] INACT_LAST = INACT_W'(INACTIVITY_SECONDS - 1);

    logic p_mode, p_inc, p_stop;

    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode (
        .clk(clk), .reset_n(reset_n), .btn(mode_btn), .press(p_mode));
    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc (
        .clk(clk), .reset_n(reset_n), .btn(inc_btn), .press(p_inc));
    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_stop (
        .clk(clk), .reset_n(reset_n), .btn(stop_btn), .press(p_stop));

    mode_t              state;
    logic               fired;
    logic [RING_W-1:0]  ring_cnt;
    logic [INACT_W-1:0] inact_cnt;
    logic               trigger;

    assign mode = state;

    // Alarm is suppressed while the alarm time itself is being edited
    assign trigger = alarm_en && (cur_hours == alarm_hours) &&
                     (cur_minutes == alarm_minutes) && (cur_seconds == '0) &&
                     !fired && (state != MODE_SET_AHR) && (state != MODE_SET_AMIN);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= MODE_RUN;
            edit_hours    <= '0;
            edit_minutes  <= '0;
            load_time     <= 1'b0;
            alarm_hours   <= '0;
            alarm_minutes <= '0;
            alarm_en      <= 1'b0;
            alarm_ring    <= 1'b0;
            fired         <= 1'b0;
            ring_cnt      <= '0;
            inact_cnt     <= '0;
        end else begin
            load_time <= 1'b0;

            // Mode press always takes priority over an inc press
            case (state)
                MODE_RUN: begin
                    inact_cnt <= '0;
                    if (p_mode) begin
                        state        <= MODE_SET_HR;
                        edit_hours   <= cur_hours;
                        edit_minutes <= cur_minutes;
                    end
                    if (p_stop && !alarm_ring)
                        alarm_en <= ~alarm_en;
                end
                MODE_SET_HR: begin
                    if (p_mode)     state <= MODE_SET_MIN;
                    else if (p_inc) edit_hours <= inc_hour(edit_hours);
                end
                MODE_SET_MIN: begin
                    if (p_mode) begin
                        state     <= MODE_SET_AHR;
                        load_time <= 1'b1;
                    end else if (p_inc)
                        edit_minutes <= inc_min(edit_minutes);
                end
                MODE_SET_AHR: begin
                    if (p_mode)     state <= MODE_SET_AMIN;
                    else if (p_inc) alarm_hours <= inc_hour(alarm_hours);
                end
                MODE_SET_AMIN: begin
                    if (p_mode)     state <= MODE_RUN;
                    else if (p_inc) alarm_minutes <= inc_min(alarm_minutes);
                end
                default: state <= MODE_RUN;
            endcase

            // Inactivity timeout abandons the edit without loading
            if (state != MODE_RUN) begin
                if (p_mode || p_inc || p_stop)
                    inact_cnt <= '0;
                else if (sec_tick) begin
                    if (inact_cnt == INACT_LAST) begin
                        inact_cnt <= '0;
                        state     <= MODE_RUN;
                    end else
                        inact_cnt <= inact_cnt + INACT_W'(1);
                end
            end

            // One trigger per matching minute
            if (trigger)
                fired <= 1'b1;
            else if (cur_minutes != alarm_minutes)
                fired <= 1'b0;

            // Stop beats a simultaneous trigger
            if (p_stop) begin
                alarm_ring <= 1'b0;
                ring_cnt   <= '0;
            end else if (trigger) begin
                alarm_ring <= 1'b1;
                ring_cnt   <= '0;
            end else if (alarm_ring) begin
                if (!alarm_en)
                    alarm_ring <= 1'b0;
                else if (sec_tick) begin
                    if (ring_cnt == RING_LAST) begin
                        alarm_ring <= 1'b0;
                        ring_cnt   <= '0;
                    end else
                        ring_cnt <= ring_cnt + RING_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_watch_mode_ctrl.sv
// Bench for watch_mode_ctrl: table of button operations with expected
// register state, plus sequences for alarm, inactivity and reset.
module tb_watch_mode_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       mode_btn, inc_btn, stop_btn, sec_tick;
    logic [4:0] cur_hours;
    logic [5:0] cur_minutes, cur_seconds;
    logic [4:0] edit_hours, alarm_hours;
    logic [5:0] edit_minutes, alarm_minutes;
    logic       load_time, alarm_en, alarm_ring;
    logic [2:0] mode;

    always #5 clk = ~clk;

    watch_mode_ctrl #(
        .DEBOUNCE_CYCLES(4), .RING_SECONDS(5), .INACTIVITY_SECONDS(3)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .mode_btn(mode_btn), .inc_btn(inc_btn), .stop_btn(stop_btn),
        .sec_tick(sec_tick),
        .cur_hours(cur_hours), .cur_minutes(cur_minutes), .cur_seconds(cur_seconds),
        .edit_hours(edit_hours), .edit_minutes(edit_minutes), .load_time(load_time),
        .alarm_hours(alarm_hours), .alarm_minutes(alarm_minutes),
        .alarm_en(alarm_en), .alarm_ring(alarm_ring), .mode(mode)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef enum {OP_MODE, OP_INC, OP_STOP, OP_MODEINC, OP_GLITCH, OP_HOLDINC} op_t;
    typedef struct {
        op_t op; int reps; int ld;
        int mode; int eh; int em; int ah; int am; int en;
    } vec_t;
    typedef struct { int h; int m; } load_t;

    vec_t  vecs[$];
    vec_t  exp_q[$];
    load_t load_q[$];
    load_t le;
    vec_t  ev;

    task automatic add(input op_t op, input int reps, input int ld, input int md,
                       input int eh, input int em, input int ah, input int am, input int en);
        vec_t v;
        v = '{op, reps, ld, md, eh, em, ah, am, en};
        vecs.push_back(v);
    endtask

    task automatic drive(input op_t op);
        int hold;
        hold = (op == OP_GLITCH) ? 2 : (op == OP_HOLDINC) ? 10 : 8;
        @(negedge clk);
        case (op)
            OP_MODE:    mode_btn = 1'b1;
            OP_STOP:    stop_btn = 1'b1;
            OP_MODEINC: begin mode_btn = 1'b1; inc_btn = 1'b1; end
            default:    inc_btn = 1'b1;
        endcase
        repeat (hold) @(negedge clk);
        mode_btn = 1'b0; inc_btn = 1'b0; stop_btn = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic tick();
        @(negedge clk) sec_tick = 1'b1;
        @(negedge clk) sec_tick = 1'b0;
    endtask

    // load_time monitor: each strobe is matched against the expected edit value
    int load_cnt = 0;
    int load_run = 0;
    always @(negedge clk) begin
        if (load_time) begin
            load_cnt++;
            load_run++;
            if (load_q.size() == 0)
                check("load_unexpected", load_cnt, 0);
            else begin
                le = load_q.pop_front();
                check("load_edit_h", edit_hours, le.h);
                check("load_edit_m", edit_minutes, le.m);
            end
        end else begin
            if (load_run > 0) check("load_width", load_run, 1);
            load_run = 0;
        end
    end

    initial begin
        reset_n = 1'b0;
        mode_btn = 1'b0; inc_btn = 1'b0; stop_btn = 1'b0; sec_tick = 1'b0;
        cur_hours = 5'd10; cur_minutes = 6'd20; cur_seconds = 6'd5;

        add(OP_MODE,     1, 0, 1, 10, 20, 0,  0, 0);
        add(OP_INC,     13, 0, 1, 23, 20, 0,  0, 0);
        add(OP_INC,      1, 0, 1,  0, 20, 0,  0, 0);
        add(OP_GLITCH,   1, 0, 1,  0, 20, 0,  0, 0);
        add(OP_HOLDINC,  1, 0, 1,  1, 20, 0,  0, 0);
        add(OP_INC,     23, 0, 1,  0, 20, 0,  0, 0);
        add(OP_MODEINC,  1, 0, 2,  0, 20, 0,  0, 0);
        add(OP_INC,     39, 0, 2,  0, 59, 0,  0, 0);
        add(OP_INC,      1, 0, 2,  0,  0, 0,  0, 0);
        add(OP_MODE,     1, 1, 3,  0,  0, 0,  0, 0);
        add(OP_INC,      7, 0, 3,  0,  0, 7,  0, 0);
        add(OP_MODEINC,  1, 0, 4,  0,  0, 7,  0, 0);
        add(OP_INC,     30, 0, 4,  0,  0, 7, 30, 0);
        add(OP_MODE,     1, 0, 0,  0,  0, 7, 30, 0);
        add(OP_STOP,     1, 0, 0,  0,  0, 7, 30, 1);
        add(OP_INC,      1, 0, 0,  0,  0, 7, 30, 1);

        repeat (3) @(negedge clk);
        check("rst_mode", mode, 0);
        check("rst_edit_h", edit_hours, 0);
        check("rst_alarm_en", alarm_en, 0);
        check("rst_ring", alarm_ring, 0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].ld != 0) load_q.push_back('{vecs[i].eh, vecs[i].em});
            for (int r = 0; r < vecs[i].reps; r++) drive(vecs[i].op);
            exp_q.push_back(vecs[i]);
            ev = exp_q.pop_front();
            check($sformatf("v%0d_mode", i), mode, ev.mode);
            check($sformatf("v%0d_edit_h", i), edit_hours, ev.eh);
            check($sformatf("v%0d_edit_m", i), edit_minutes, ev.em);
            check($sformatf("v%0d_alarm_h", i), alarm_hours, ev.ah);
            check($sformatf("v%0d_alarm_m", i), alarm_minutes, ev.am);
            check($sformatf("v%0d_alarm_en", i), alarm_en, ev.en);
        end

        // Alarm trigger, timeout, no retrigger within the minute, retrigger
        @(negedge clk);
        cur_hours = 5'd7; cur_minutes = 6'd30; cur_seconds = 6'd0;
        @(negedge clk);
        check("ring_on", alarm_ring, 1);
        cur_seconds = 6'd1;
        repeat (4) tick();
        check("ring_after4", alarm_ring, 1);
        tick();
        check("ring_after5", alarm_ring, 0);
        cur_seconds = 6'd0;
        repeat (3) @(negedge clk);
        check("no_retrigger", alarm_ring, 0);
        cur_minutes = 6'd31;
        @(negedge clk) cur_minutes = 6'd30;
        @(negedge clk);
        check("retrigger", alarm_ring, 1);
        cur_seconds = 6'd1;
        drive(OP_STOP);
        check("stop_ring", alarm_ring, 0);
        check("stop_keeps_en", alarm_en, 1);
        drive(OP_STOP);
        check("stop_toggle_en", alarm_en, 0);
        check("stop_no_ring", alarm_ring, 0);

        // Inactivity abort
        cur_hours = 5'd10; cur_minutes = 6'd20; cur_seconds = 6'd5;
        drive(OP_MODE);
        check("inact_enter", mode, 1);
        drive(OP_INC);
        drive(OP_INC);
        check("inact_edit_h", edit_hours, 12);
        repeat (2) tick();
        check("inact_2ticks", mode, 1);
        tick();
        check("inact_abort", mode, 0);
        check("inact_alarm_h", alarm_hours, 7);

        // Reset mid-operation with buttons held
        drive(OP_MODE);
        @(negedge clk);
        mode_btn = 1'b1; inc_btn = 1'b1;
        repeat (10) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("arst_mode", mode, 0);
        check("arst_edit_h", edit_hours, 0);
        check("arst_edit_m", edit_minutes, 0);
        check("arst_alarm_h", alarm_hours, 0);
        check("arst_alarm_m", alarm_minutes, 0);
        check("arst_en", alarm_en, 0);
        check("arst_ring", alarm_ring, 0);
        check("arst_load", load_time, 0);
        @(negedge clk) reset_n = 1'b1;
        repeat (20) @(negedge clk);
        check("held_no_press", mode, 0);
        check("held_no_edit", edit_hours, 0);
        mode_btn = 1'b0; inc_btn = 1'b0;
        repeat (12) @(negedge clk);
        drive(OP_MODE);
        check("repress_mode", mode, 1);
        check("repress_edit_h", edit_hours, 10);

        check("load_total", load_cnt, 1);
        check("load_q_empty", load_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/watch_mode_ctrl.md
Name: watch_mode_ctrl

Overview:
Button-driven mode controller and alarm scheduler for the digital watch. It conditions three raw push-buttons and runs a mode FSM for setting the time and the alarm. It issues a one-cycle load strobe, with the edited time, to the watch counter datapath. It owns the alarm registers, alarm enable and alarm ringing timeout, using the watch's 1 Hz tick and current-time outputs.

Parameters:
DEBOUNCE_CYCLES, 1_000_000, clk cycles a synchronized button level must stay stable to be accepted
RING_SECONDS, 60, sec_tick pulses the alarm rings before auto-silencing
INACTIVITY_SECONDS, 30, sec_tick pulses without a press before a SET mode aborts to RUN

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
mode_btn  in  1  raw mode button, asynchronous, active-high
inc_btn  in  1  raw increment button
stop_btn  in  1  raw stop/alarm-toggle button
sec_tick  in  1  one-cycle pulse per second from the watch
cur_hours  in  5  current hour, 0..23
cur_minutes  in  6  current minute, 0..59
cur_seconds  in  6  current second, 0..59
edit_hours  out  5  hour value being edited, loaded on load_time
edit_minutes  out  6  minute value being edited
load_time  out  1  one-cycle strobe: watch loads edit_hours:edit_minutes:00
alarm_hours  out  5  stored alarm hour
alarm_minutes  out  6  stored alarm minute
alarm_en  out  1  alarm armed
alarm_ring  out  1  level, high while ringing
mode  out  3  FSM state: 0 RUN, 1 SET_HR, 2 SET_MIN, 3 SET_AHR, 4 SET_AMIN

Behaviour:
- Reset (reset_n=0, async): every output 0, mode=RUN, all counters and conditioner state cleared.
- Button conditioning, per button:
  - 2-FF synchronizer feeds a debounce counter.
  - The debounced level updates only after DEBOUNCE_CYCLES consecutive equal samples; any change restarts the count.
  - A rising edge of the debounced level gives a one-cycle press pulse.
  - Press latency from a clean raw edge: 2 + DEBOUNCE_CYCLES + 1 cycles.
- FSM, all transitions on press pulses:
  - RUN -mode-> SET_HR: edit_hours<=cur_hours, edit_minutes<=cur_minutes on the transition cycle.
  - SET_HR: inc increments edit_hours, wrapping 23->0. mode -> SET_MIN.
  - SET_MIN: inc increments edit_minutes, wrapping 59->0. mode -> SET_AHR, and load_time=1 for exactly the cycle after the press.
  - SET_AHR: inc increments alarm_hours, wrapping 23->0. mode -> SET_AMIN.
  - SET_AMIN: inc increments alarm_minutes, wrapping 59->0. mode -> RUN.
  - RUN: inc is ignored. A stop press toggles alarm_en only when alarm_ring=0.
- Simultaneous presses: mode beats inc (inc dropped). In RUN, stop is processed independently of mode.
- Inactivity:
  - In any SET state, a counter of sec_ticks clears on any press.
  - On reaching INACTIVITY_SECONDS, mode<=RUN. No load_time; edits are discarded. Alarm registers keep values already incremented.
- Alarm trigger:
  - Condition: alarm_en && cur_hours==alarm_hours && cur_minutes==alarm_minutes && cur_seconds==0 && !fired, with mode not SET_AHR/SET_AMIN.
  - On trigger, alarm_ring=1 the next cycle and fired<=1.
  - fired clears when cur_minutes!=alarm_minutes, so there is one trigger per match minute.
- Ringing:
  - Counts sec_ticks and clears alarm_ring after RING_SECONDS ticks.
  - A stop press while ringing clears alarm_ring the next cycle and does not change alarm_en.
  - Stop press and trigger in the same cycle: stop wins, no ring, fired set.
  - alarm_en cleared while ringing (only possible via reset): ring stops.
- Ringing continues through mode changes. alarm_ring is a level; flashing is the display's job.
- Counter widths: $clog2(param+1). All arithmetic is unsigned with explicit wrap compares; no modulo operators.

Decomposition:
- Shared package watch_pkg:
  - mode encodings MODE_RUN..MODE_SET_AMIN
  - HOUR_MAX=23, MIN_MAX=59
  - HOUR_W=5, MIN_W=6
- Sub-module btn_conditioner (sync + debounce + rising-edge pulse, parameter DEBOUNCE_CYCLES), instantiated three times.

Test Plan:
(All with DEBOUNCE_CYCLES=4, RING_SECONDS=5, INACTIVITY_SECONDS=3.)
- Reset: assert reset_n=0 mid-operation with buttons held -> all outputs 0 immediately, mode=0. After release, held buttons produce no press until released and re-pressed.
- Time set: cur=10:20.
  - mode press -> mode=1, edit_hours=10.
  - 14 inc -> edit_hours=0.
  - mode -> mode=2, edit_minutes=20; 40 inc -> 0.
  - mode -> load_time high exactly 1 cycle, edit=00:00, mode=3.
- Debounce: 2-cycle inc glitch in SET_HR -> no change. Inc held 10 cycles -> exactly +1. Mode+inc pressed together -> mode advances, value unchanged.
- Alarm:
  - Set alarm 07:30, return to RUN, stop press -> alarm_en=1.
  - Drive cur 07:30:00 -> alarm_ring=1 next cycle; cleared after 5 sec_ticks.
  - Holding 07:30:xx -> no retrigger. Then 07:31 -> 07:30:00 -> rings again.
- Stop during ring -> alarm_ring=0 next cycle, alarm_en stays 1. Stop in RUN, not ringing -> alarm_en toggles to 0.
- Inactivity: enter SET_HR, 2 inc, then 3 sec_ticks with no press -> mode=0, load_time never asserted.
